// File: rtl/yutorina_spm_arbiter_pkg.sv
// Shared types and constants for the SPM data-port arbiter.
package yutorina_spm_arbiter_pkg;

   // Access direction as carried on the rw lines.
   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   // Arbiter FSM: one transaction walks IDLE -> ACCESS -> WAIT -> DONE.
   typedef enum logic [1:0] {
      SPM_ARB_IDLE   = 2'h0,
      SPM_ARB_ACCESS = 2'h1,
      SPM_ARB_WAIT   = 2'h2,
      SPM_ARB_DONE   = 2'h3
   } spm_arb_state_t;

   // Identity of the requester owning the current (or last) transaction.
   typedef enum logic {
      SPM_ARB_GNT_CPU = 1'b0,
      SPM_ARB_GNT_BUS = 1'b1
   } spm_arb_gnt_t;

endpackage

// File: rtl/yutorina_spm_arb_sel.sv
// Combinational winner select for the SPM arbiter.
// Build option: define SPM_ARB_RR_EN for round-robin on contention;
// otherwise the CPU has fixed priority over the bus.
module yutorina_spm_arb_sel
   import yutorina_spm_arbiter_pkg::*;
(
   input  logic         c_req_,
   input  logic         b_req_,
   input  spm_arb_gnt_t gnt,
   output logic         valid,
   output spm_arb_gnt_t winner
);

`ifndef SPM_ARB_RR_EN
   // Fixed priority never looks at the previous grant.
   logic unused_gnt;
   assign unused_gnt = gnt;
`endif

   // Pick a winner among the active-low requests.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      valid  = ~c_req_ | ~b_req_;
      winner = SPM_ARB_GNT_CPU;
`ifdef SPM_ARB_RR_EN
      if (!c_req_ && !b_req_)
         winner = (gnt == SPM_ARB_GNT_CPU) ? SPM_ARB_GNT_BUS : SPM_ARB_GNT_CPU;
      else if (!b_req_)
         winner = SPM_ARB_GNT_BUS;
`else
      if (c_req_ && !b_req_)
         winner = SPM_ARB_GNT_BUS;
`endif
   end

endmodule

// File: rtl/yutorina_spm_arbiter.sv
// Arbiter sharing the SPM data port between the CPU data stage and the
// bus-side loader. One access in flight, four cycles per access, all
// outputs registered. Build option SPM_ARB_RR_EN selects round-robin.
module yutorina_spm_arbiter
   import yutorina_spm_arbiter_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_,
   // CPU requester
   input  logic              c_req_,
   input  logic              c_rw,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_w_data,
   output logic [DATA_W-1:0] c_r_data,
   output logic              c_rdy_,
   // Bus requester
   input  logic              b_req_,
   input  logic              b_rw,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_w_data,
   output logic [DATA_W-1:0] b_r_data,
   output logic              b_rdy_,
   // SPM data port
   output logic              spm_as_,
   output logic              spm_rw,
   output logic [ADDR_W-1:0] spm_addr,
   output logic [DATA_W-1:0] spm_w_data,
   input  logic [DATA_W-1:0] spm_r_data
);

   spm_arb_state_t state, next_state;
   spm_arb_gnt_t   gnt;
   spm_arb_gnt_t   sel_winner;
   logic           sel_valid;

   yutorina_spm_arb_sel u_sel (
      .c_req_ (c_req_),
      .b_req_ (b_req_),
      .gnt    (gnt),
      .valid  (sel_valid),
      .winner (sel_winner)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (!reset_) state <= SPM_ARB_IDLE;
      else         state <= next_state;
   end

   // Next-state logic: requests are only looked at in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         SPM_ARB_IDLE:   if (sel_valid) next_state = SPM_ARB_ACCESS;
         SPM_ARB_ACCESS: next_state = SPM_ARB_WAIT;
         SPM_ARB_WAIT:   next_state = SPM_ARB_DONE;
         SPM_ARB_DONE:   next_state = SPM_ARB_IDLE;
         default:        next_state = SPM_ARB_IDLE;
      endcase
   end

   // Registered outputs: latch the winner's fields, strobe the SPM, return data and ready.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         gnt        <= SPM_ARB_GNT_BUS;   // so the CPU wins the first contention under round-robin
         spm_as_    <= 1'b1;
         spm_rw     <= READ;
         spm_addr   <= '0;
         spm_w_data <= '0;
         c_rdy_     <= 1'b1;
         b_rdy_     <= 1'b1;
         c_r_data   <= '0;
         b_r_data   <= '0;
      end else begin
         case (state)
            SPM_ARB_IDLE: begin
               if (sel_valid) begin
                  gnt     <= sel_winner;
                  spm_as_ <= 1'b0;
                  if (sel_winner == SPM_ARB_GNT_CPU) begin
                     spm_rw     <= c_rw;
                     spm_addr   <= c_addr;
                     spm_w_data <= c_w_data;
                  end else begin
                     spm_rw     <= b_rw;
                     spm_addr   <= b_addr;
                     spm_w_data <= b_w_data;
                  end
               end
            end
            SPM_ARB_ACCESS: spm_as_ <= 1'b1;
            SPM_ARB_WAIT: begin
               // Read data from the SPM is valid now; writes leave r_data alone.
               if (gnt == SPM_ARB_GNT_CPU) begin
                  c_rdy_ <= 1'b0;
                  if (spm_rw == READ) c_r_data <= spm_r_data;
               end else begin
                  b_rdy_ <= 1'b0;
                  if (spm_rw == READ) b_r_data <= spm_r_data;
               end
            end
            SPM_ARB_DONE: begin
               c_rdy_ <= 1'b1;
               b_rdy_ <= 1'b1;
            end
            default: spm_as_ <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_yutorina_spm_arbiter.sv
// Self-checking bench for yutorina_spm_arbiter with a behavioural SPM stub.
module tb_yutorina_spm_arbiter;
   import yutorina_spm_arbiter_pkg::*;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   logic              clk, reset_;
   logic              c_req_, c_rw, c_rdy_;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_w_data, c_r_data;
   logic              b_req_, b_rw, b_rdy_;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_w_data, b_r_data;
   logic              spm_as_, spm_rw;
   logic [ADDR_W-1:0] spm_addr;
   logic [DATA_W-1:0] spm_w_data, spm_r_data;

   yutorina_spm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset_(reset_),
      .c_req_(c_req_), .c_rw(c_rw), .c_addr(c_addr), .c_w_data(c_w_data),
      .c_r_data(c_r_data), .c_rdy_(c_rdy_),
      .b_req_(b_req_), .b_rw(b_rw), .b_addr(b_addr), .b_w_data(b_w_data),
      .b_r_data(b_r_data), .b_rdy_(b_rdy_),
      .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr),
      .spm_w_data(spm_w_data), .spm_r_data(spm_r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous SPM: samples the port on the strobe edge, read data valid next cycle.
   logic [DATA_W-1:0] spm_mem [0:4095];
   always @(posedge clk) begin
      if (!spm_as_) begin
         if (spm_rw == WRITE) spm_mem[spm_addr] <= spm_w_data;
         else                 spm_r_data <= spm_mem[spm_addr];
      end
   end

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_c_rd, exp_b_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit who, input logic req, input logic rw,
                        input logic [11:0] a, input logic [31:0] d);
      if (!who) begin c_req_ = req; c_rw = rw; c_addr = a; c_w_data = d; end
      else      begin b_req_ = req; b_rw = rw; b_addr = a; b_w_data = d; end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_as"},   spm_as_, 1'b1);
      check({tag, "_rw"},   spm_rw, READ);
      check({tag, "_addr"}, spm_addr, 32'h0);
      check({tag, "_wd"},   spm_w_data, 32'h0);
      check({tag, "_crdy"}, c_rdy_, 1'b1);
      check({tag, "_brdy"}, b_rdy_, 1'b1);
      check({tag, "_crd"},  c_r_data, 32'h0);
      check({tag, "_brd"},  b_r_data, 32'h0);
   endtask

   typedef struct {
      bit          who;    // 0 = CPU, 1 = bus
      logic        rw;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;  // expected read data (reads only)
   } vec_t;

   // One complete transaction with nobody else requesting; starts and ends at a negedge in IDLE.
   task automatic do_txn(input vec_t v);
      logic [31:0] own_exp, oth_exp;
      own_exp = v.who ? exp_b_rd : exp_c_rd;
      oth_exp = v.who ? exp_c_rd : exp_b_rd;
      drive(v.who, 1'b0, v.rw, v.addr, v.wdata);
      @(negedge clk);
      check("txn_as_low", spm_as_, 1'b0);
      check("txn_rw",     spm_rw, v.rw);
      check("txn_addr",   spm_addr, v.addr);
      check("txn_wdata",  spm_w_data, v.wdata);
      @(negedge clk);
      check("txn_as_high", spm_as_, 1'b1);
      check("txn_rdy_early", v.who ? b_rdy_ : c_rdy_, 1'b1);
      @(negedge clk);
      if (v.rw == READ) own_exp = v.rdata;
      check("txn_rdy_low", v.who ? b_rdy_ : c_rdy_, 1'b0);
      check("txn_rdata",   v.who ? b_r_data : c_r_data, own_exp);
      check("txn_other_rdy",   v.who ? c_rdy_ : b_rdy_, 1'b1);
      check("txn_other_rdata", v.who ? c_r_data : b_r_data, oth_exp);
      drive(v.who, 1'b1, v.rw, v.addr, v.wdata);
      @(negedge clk);
      check("txn_rdy_release", v.who ? b_rdy_ : c_rdy_, 1'b1);
      check("txn_rdata_hold",  v.who ? b_r_data : c_r_data, own_exp);
      if (v.who) exp_b_rd = own_exp; else exp_c_rd = own_exp;
   endtask

   // Both requesters assert in the same cycle and hold until served.
   task automatic contend(input bit bus_first);
      logic [11:0] a_first, a_second;
      a_first  = bus_first ? 12'h031 : 12'h030;
      a_second = bus_first ? 12'h030 : 12'h031;
      drive(1'b0, 1'b0, WRITE, 12'h030, 32'h1111_1111);
      drive(1'b1, 1'b0, WRITE, 12'h031, 32'h2222_2222);
      @(negedge clk);
      check("cont_first_addr", spm_addr, a_first);
      check("cont_first_as", spm_as_, 1'b0);
      repeat (2) @(negedge clk);
      check("cont_first_rdy",  bus_first ? b_rdy_ : c_rdy_, 1'b0);
      check("cont_second_idle", bus_first ? c_rdy_ : b_rdy_, 1'b1);
      drive(bus_first, 1'b1, WRITE, 12'h0, 32'h0);
      @(negedge clk);
      check("cont_gap_rdy", c_rdy_ & b_rdy_, 1'b1);
      @(negedge clk);
      check("cont_second_addr", spm_addr, a_second);
      check("cont_second_as", spm_as_, 1'b0);
      repeat (2) @(negedge clk);
      check("cont_second_rdy", bus_first ? c_rdy_ : b_rdy_, 1'b0);
      drive(!bus_first, 1'b1, WRITE, 12'h0, 32'h0);
      @(negedge clk);
      check("cont_end_rdy", c_rdy_ & b_rdy_, 1'b1);
   endtask

   // Random phase: transaction-level model of memory and per-requester read data.
   logic [31:0] model_mem [0:15];

   task automatic random_phase(input int n_cycles, input int drain_budget);
      bit          pend[2];
      logic        rw_q[2];
      logic [3:0]  idx_q[2];
      logic [31:0] wd_q[2];
      int          age[2];
      bit          prev_low[2];
      logic [31:0] exp_rd[2];
      logic        rdy_v[2];
      logic [31:0] rd_v[2];
      int          cyc;
      exp_rd[0] = exp_c_rd;
      exp_rd[1] = exp_b_rd;
      for (int r = 0; r < 2; r++) begin pend[r] = 0; age[r] = 0; prev_low[r] = 0; end
      cyc = 0;
      while (cyc < n_cycles || pend[0] || pend[1]) begin
         if (cyc >= n_cycles + drain_budget) begin
            check("rnd_drain_pending", {30'b0, pend[1], pend[0]}, 32'h0);
            break;
         end
         @(negedge clk);
         rdy_v[0] = c_rdy_;   rdy_v[1] = b_rdy_;
         rd_v[0]  = c_r_data; rd_v[1]  = b_r_data;
         check("rnd_single_rdy", rdy_v[0] | rdy_v[1], 1'b1);
         for (int r = 0; r < 2; r++) begin
            if (!rdy_v[r]) begin
               check("rnd_rdy_legal", pend[r] && !prev_low[r], 1'b1);
               if (pend[r]) begin
                  if (rw_q[r] == READ) exp_rd[r] = model_mem[idx_q[r]];
                  else                 model_mem[idx_q[r]] = wd_q[r];
                  pend[r] = 0;
                  drive(r[0], 1'b1, rw_q[r], {8'h10, idx_q[r]}, wd_q[r]);
               end
            end else if (pend[r]) begin
               age[r]++;
               if (age[r] > 200) begin
                  check("rnd_timeout_age", age[r], 32'd0);
                  pend[r] = 0;
                  drive(r[0], 1'b1, rw_q[r], {8'h10, idx_q[r]}, wd_q[r]);
               end
            end else if (cyc < n_cycles && $urandom_range(3) == 0) begin
               pend[r]  = 1;
               age[r]   = 0;
               rw_q[r]  = $urandom_range(1);
               idx_q[r] = 4'($urandom_range(15));
               wd_q[r]  = $urandom;
               drive(r[0], 1'b0, rw_q[r], {8'h10, idx_q[r]}, wd_q[r]);
            end
            check("rnd_rdata", rd_v[r], exp_rd[r]);
            prev_low[r] = !rdy_v[r];
         end
         cyc++;
      end
      exp_c_rd = exp_rd[0];
      exp_b_rd = exp_rd[1];
   endtask

   initial begin
      vec_t vecs [9];
      vecs[0] = '{1'b0, WRITE, 12'h010, 32'hDEAD_BEEF, 32'h0};
      vecs[1] = '{1'b0, READ,  12'h010, 32'h1234_5678, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, WRITE, 12'hFFF, 32'h0000_0001, 32'h0};
      vecs[3] = '{1'b0, READ,  12'hFFF, 32'h0BAD_F00D, 32'h0000_0001};
      vecs[4] = '{1'b1, READ,  12'h010, 32'h0,         32'hDEAD_BEEF};
      vecs[5] = '{1'b0, WRITE, 12'h000, 32'hA5A5_5A5A, 32'h0};
      vecs[6] = '{1'b1, READ,  12'h000, 32'h0,         32'hA5A5_5A5A};
      vecs[7] = '{1'b1, WRITE, 12'h010, 32'hCAFE_F00D, 32'h0};
      vecs[8] = '{1'b0, READ,  12'h010, 32'h0,         32'hCAFE_F00D};

      for (int i = 0; i < 4096; i++) spm_mem[i] = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      spm_r_data = '0;
      exp_c_rd = '0;
      exp_b_rd = '0;
      drive(1'b0, 1'b1, READ, 12'h0, 32'h0);
      drive(1'b1, 1'b1, READ, 12'h0, 32'h0);

      // Power-on reset.
      reset_ = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      reset_ = 1'b1;
      @(negedge clk);
      check_reset_outputs("idle");

      // Single transactions from the table.
      for (int i = 0; i < 9; i++) do_txn(vecs[i]);

      // Reset asserted for one cycle while a CPU write is in ACCESS.
      drive(1'b0, 1'b0, WRITE, 12'h020, 32'h5555_AAAA);
      @(negedge clk);
      check("rst_mid_as", spm_as_, 1'b0);
      reset_ = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      reset_ = 1'b1;
      drive(1'b0, 1'b1, WRITE, 12'h020, 32'h5555_AAAA);
      exp_c_rd = '0;
      exp_b_rd = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rst_after_rdy", c_rdy_ & b_rdy_, 1'b1);
         check("rst_after_as", spm_as_, 1'b1);
      end

      // Contention straight out of reset: CPU first in both modes.
      contend(1'b0);
      // After a CPU-only access, round-robin hands the next contention to the bus.
      do_txn('{1'b0, WRITE, 12'h032, 32'h3333_3333, 32'h0});
`ifdef SPM_ARB_RR_EN
      contend(1'b1);
`else
      contend(1'b0);
`endif

      // Bus request low for only the E0 cycle: the access still completes.
      drive(1'b1, 1'b0, WRITE, 12'h040, 32'h0000_0033);
      @(negedge clk);
      drive(1'b1, 1'b1, WRITE, 12'h040, 32'h0000_0033);
      check("pulse_e0_as", spm_as_, 1'b0);
      check("pulse_e0_addr", spm_addr, 32'h040);
      repeat (2) @(negedge clk);
      check("pulse_e0_rdy", b_rdy_, 1'b0);
      @(negedge clk);
      check("pulse_e0_rdy_end", b_rdy_, 1'b1);

      // Bus request low only during WAIT of a CPU read: ignored.
      drive(1'b0, 1'b0, READ, 12'h040, 32'h0);
      repeat (2) @(negedge clk);
      drive(1'b1, 1'b0, WRITE, 12'h041, 32'h0000_0044);
      @(negedge clk);
      drive(1'b1, 1'b1, WRITE, 12'h041, 32'h0000_0044);
      check("pulse_wait_crdy", c_rdy_, 1'b0);
      check("pulse_wait_crd", c_r_data, 32'h0000_0033);
      exp_c_rd = 32'h0000_0033;
      drive(1'b0, 1'b1, READ, 12'h040, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("pulse_wait_brdy", b_rdy_, 1'b1);
         check("pulse_wait_as", spm_as_, 1'b1);
      end

      // CPU holds its request: one access every four cycles, each ready one cycle wide.
      drive(1'b0, 1'b0, READ, 12'h040, 32'h0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check("hold_rdy", c_rdy_, (i == 3 || i == 7 || i == 11) ? 1'b0 : 1'b1);
         check("hold_rdata", c_r_data, 32'h0000_0033);
         if (i == 11) drive(1'b0, 1'b1, READ, 12'h040, 32'h0);
      end
      check("hold_idle_as", spm_as_, 1'b1);

      // Randomised traffic from both requesters against the transaction model.
      random_phase(800, 400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
